// File: rtl/regfile_reader_if.sv
// Output beat stream of the register file dump engine.
// One beat per accepted valid/ready handshake.
interface regfile_reader_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_idx;
  logic          out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_idx,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_idx,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/regfile_reader.sv
// Walks the register file read port 0..NREGS-1 and streams
// each entry as one valid/ready beat; abort cancels silently.
module regfile_reader #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic [AW-1:0]         rd_addr,
  input  logic [DW-1:0]         rd_data,
  regfile_reader_if.master      out,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  state_t        state, state_n;
  logic [AW-1:0] ptr, ptr_n;
  logic          valid_q, valid_n;
  logic [DW-1:0] data_q, data_n;
  logic [AW-1:0] idx_q, idx_n;
  logic          done_q, done_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      valid_q <= valid_n;
      data_q  <= data_n;
      idx_q   <= idx_n;
      done_q  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    valid_n = valid_q;
    data_n  = data_q;
    idx_n   = idx_q;
    done_n  = 1'b0;
    if (abort) begin
      state_n = IDLE;
      valid_n = 1'b0;
      ptr_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            ptr_n   = '0;
            state_n = LOAD;
          end
        end
        LOAD: begin
          data_n  = rd_data;
          idx_n   = ptr;
          valid_n = 1'b1;
          ptr_n   = ptr + AW'(1);
          state_n = SEND;
        end
        SEND: begin
          if (out.out_ready) begin
            if (idx_q == LAST_IDX) begin
              valid_n = 1'b0;
              done_n  = 1'b1;
              state_n = IDLE;
            end else begin
              // refill behind the accepted beat for back-to-back output
              data_n = rd_data;
              idx_n  = ptr;
              ptr_n  = ptr + AW'(1);
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign rd_addr       = ptr;
  assign out.out_valid = valid_q;
  assign out.out_data  = data_q;
  assign out.out_idx   = idx_q;
  assign out.out_last  = valid_q && (idx_q == LAST_IDX);
  assign busy          = (state != IDLE);
  assign done          = done_q;

endmodule

// File: tb/tb_regfile_reader.sv
// Scoreboard bench for regfile_reader: stimulus queues expected
// beats, a negedge monitor pops and compares on each handshake.
module tb_regfile_reader;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;

  regfile_reader_if #(.AW(AW), .DW(DW)) bus ();

  regfile_reader #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .out     (bus.master),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] regs [NREGS];
  logic          we = 1'b0;
  logic [AW-1:0] wa = '0;
  logic [DW-1:0] wd = '0;

  always @(posedge clk) if (we) regs[wa] <= wd;
  assign rd_data = regs[rd_addr];

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] idx;
    logic          last;
  } beat_t;

  beat_t exp_q [$];
  int n_cmp  = 0;
  int n_err  = 0;
  int n_done = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Expected contents for one dump of indices 0..n-1
  task automatic push_dump(int n, logic [DW-1:0] v20);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = (i == 20) ? v20 : 32'hA5A5_0000 + i;
      b.idx  = AW'(i);
      b.last = (i == NREGS - 1);
      exp_q.push_back(b);
    end
  endtask

  beat_t         e;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] prev_data;
  logic [AW-1:0] prev_idx;

  always @(negedge clk) begin
    if (done) n_done++;
    if (stall_prev && bus.out_valid) begin
      check("stall_data", bus.out_data, prev_data);
      check("stall_idx", bus.out_idx, prev_idx);
    end
    stall_prev = bus.out_valid && !bus.out_ready;
    prev_data  = bus.out_data;
    prev_idx   = bus.out_idx;
    if (bus.out_valid && bus.out_ready && !rst) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL extra_beat: got idx %0d want none", bus.out_idx);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", bus.out_data, e.data);
        check("beat_idx", bus.out_idx, e.idx);
        check("beat_last", bus.out_last, e.last);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_done(string name, bit rnd, output int cycles);
    cycles = 0;
    while (!done && cycles < 500) begin
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      tick();
      cycles++;
    end
    bus.out_ready = 1'b1;
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got no done want done", name);
    end
  endtask

  task automatic wait_idx(string name, logic [AW-1:0] idx);
    int k = 0;
    while (!(bus.out_valid && bus.out_idx == idx) && k < 200) begin
      tick();
      k++;
    end
    if (k >= 200) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got no idx want %0d", name, idx);
    end
  endtask

  task automatic check_reset_outs(string name);
    check({name, "_valid"}, bus.out_valid, 0);
    check({name, "_data"}, bus.out_data, 0);
    check({name, "_idx"}, bus.out_idx, 0);
    check({name, "_last"}, bus.out_last, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_addr"}, rd_addr, 0);
  endtask

  int cyc;
  int d0;

  initial begin
    bus.out_ready = 1'b1;
    for (int i = 0; i < NREGS; i++) begin
      we = 1'b1;
      wa = AW'(i);
      wd = 32'hA5A5_0000 + i;
      tick();
    end
    we = 1'b0;
    tick();
    check_reset_outs("reset");
    rst = 1'b0;
    tick();

    // basic dump, ready held high
    d0 = n_done;
    push_dump(NREGS, 32'hA5A5_0014);
    pulse_start();
    run_to_done("basic", 1'b0, cyc);
    check("basic_latency", cyc, 33);
    check("basic_busy_at_done", busy, 0);
    check("basic_drained", exp_q.size(), 0);
    tick();
    check("basic_done_width", done, 0);
    check("basic_done_count", n_done - d0, 1);

    // random backpressure
    d0 = n_done;
    push_dump(NREGS, 32'hA5A5_0014);
    pulse_start();
    run_to_done("bp", 1'b1, cyc);
    tick();
    tick();
    check("bp_drained", exp_q.size(), 0);
    check("bp_done_count", n_done - d0, 1);

    // abort while idx 10 stalled
    d0 = n_done;
    push_dump(10, 32'hA5A5_0014);
    pulse_start();
    wait_idx("abort", 5'd10);
    bus.out_ready = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_valid", bus.out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    bus.out_ready = 1'b1;
    tick();
    tick();
    check("abort_drained", exp_q.size(), 0);
    check("abort_no_done", n_done - d0, 0);
    push_dump(NREGS, 32'hA5A5_0014);
    pulse_start();
    run_to_done("restart", 1'b0, cyc);
    tick();
    check("restart_drained", exp_q.size(), 0);

    // start while busy is ignored
    d0 = n_done;
    push_dump(NREGS, 32'hA5A5_0014);
    pulse_start();
    wait_idx("sbusy", 5'd5);
    pulse_start();
    run_to_done("sbusy", 1'b0, cyc);
    tick();
    tick();
    check("sbusy_drained", exp_q.size(), 0);
    check("sbusy_done_count", n_done - d0, 1);

    // write to reg 20 in its fetch cycle
    push_dump(NREGS, 32'hA5A5_0014);
    pulse_start();
    cyc = 0;
    while (!(busy && rd_addr == 5'd20) && cyc < 100) begin
      tick();
      cyc++;
    end
    we = 1'b1;
    wa = 5'd20;
    wd = 32'hDEAD_BEEF;
    tick();
    we = 1'b0;
    run_to_done("cwr", 1'b0, cyc);
    tick();
    check("cwr_drained", exp_q.size(), 0);
    push_dump(NREGS, 32'hDEAD_BEEF);
    pulse_start();
    run_to_done("cwr2", 1'b0, cyc);
    tick();
    check("cwr2_drained", exp_q.size(), 0);

    // reset mid-dump
    d0 = n_done;
    push_dump(15, 32'hDEAD_BEEF);
    pulse_start();
    wait_idx("rst", 5'd15);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    check_reset_outs("midrst");
    rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("midrst_drained", exp_q.size(), 0);
    check("midrst_no_done", n_done - d0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
